systolic_mac_array: RTL and testbench

SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_pe.sv | 44 ++++
 rtl/systolic_mac_array.sv | 177 +++++++++++++++++
 tb/tb_systolic_mac_array.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the output-stationary systolic MAC array.
package systolic_pkg;

   localparam int DEF_ROWS   = 4;
   localparam int DEF_COLS   = 4;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ACC_W  = 40;
   localparam int DEF_KLEN_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a rightwards and b downwards through registers
// and accumulates a*b in place while enabled.
module systolic_pe #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_a,
   output logic [DATA_W-1:0] o_b,
   output logic [ACC_W-1:0]  o_acc
);

   logic [DATA_W-1:0]          r_a;
   logic [DATA_W-1:0]          r_b;
   logic [ACC_W-1:0]           r_acc;
   logic signed [2*DATA_W-1:0] w_prod;
   logic [ACC_W-1:0]           w_prodExt;

   // Signed product, sign-extended so the accumulate wraps in ACC_W two's complement.
   assign w_prod    = $signed(i_a) * $signed(i_b);
   assign w_prodExt = ACC_W'(w_prod);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (i_en) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= r_acc + w_prodExt;
      end
   end

   assign o_a   = r_a;
   assign o_b   = r_b;
   assign o_acc = r_acc;

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary ROWSxCOLS systolic matrix multiplier: streams unskewed A columns
// and B rows in, skews them internally, then drains C one row at a time.
module systolic_mac_array
   import systolic_pkg::*;
#(
   parameter int ROWS   = DEF_ROWS,
   parameter int COLS   = DEF_COLS,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int KLEN_W = DEF_KLEN_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [KLEN_W-1:0]         k_len,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ROWS*DATA_W-1:0]    a_data,
   input  logic [COLS*DATA_W-1:0]    b_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [COLS*ACC_W-1:0]     out_data,
   output logic [$clog2(ROWS)-1:0]   out_row,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done
);

   localparam int FLUSH_STEPS = ROWS + COLS - 2;
   localparam int FCNT_W      = $clog2(ROWS + COLS) + 1;
   localparam int ROW_W       = $clog2(ROWS);

   state_t              r_state;
   state_t              w_stateNext;
   logic [KLEN_W-1:0]   r_klen;
   logic [KLEN_W-1:0]   r_beatCnt;
   logic [FCNT_W-1:0]   r_flushCnt;
   logic [ROW_W-1:0]    r_row;
   logic                w_accept;
   logic                w_step;
   logic                w_clr;
   logic                w_lastBeat;
   logic                w_flushEnd;
   logic                w_rowDone;
   logic [COLS*ACC_W-1:0] w_rowData;

   logic [DATA_W-1:0] w_aIn  [ROWS];
   logic [DATA_W-1:0] w_bIn  [COLS];
   logic [DATA_W-1:0] w_aSk  [ROWS];
   logic [DATA_W-1:0] w_bSk  [COLS];
   logic [DATA_W-1:0] w_aH   [ROWS][COLS+1];
   logic [DATA_W-1:0] w_bV   [ROWS+1][COLS];
   logic [ACC_W-1:0]  w_acc  [ROWS][COLS];

   // The array only moves on an accepted beat or a flush cycle, so input stalls freeze it.
   assign w_accept   = (r_state == LOAD) && in_valid;
   assign w_step     = w_accept || (r_state == FLUSH);
   assign w_clr      = (r_state == IDLE) && start;
   assign w_lastBeat = w_accept && (r_beatCnt == r_klen - 1'b1);
   assign w_flushEnd = (r_state == FLUSH) && (r_flushCnt == FCNT_W'(FLUSH_STEPS - 1));
   assign w_rowDone  = (r_state == DRAIN) && out_ready && (r_row == ROW_W'(ROWS - 1));

   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         IDLE:    if (start) w_stateNext = (k_len == '0) ? DRAIN : LOAD;
         LOAD:    if (w_lastBeat) w_stateNext = (FLUSH_STEPS == 0) ? DRAIN : FLUSH;
         FLUSH:   if (w_flushEnd) w_stateNext = DRAIN;
         DRAIN:   if (w_rowDone) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_klen     <= '0;
         r_beatCnt  <= '0;
         r_flushCnt <= '0;
         r_row      <= '0;
      end else begin
         r_state <= w_stateNext;
         if (w_clr) begin
            r_klen     <= k_len;
            r_beatCnt  <= '0;
            r_flushCnt <= '0;
            r_row      <= '0;
         end
         if (w_accept) r_beatCnt <= r_beatCnt + 1'b1;
         if (r_state == FLUSH) r_flushCnt <= r_flushCnt + 1'b1;
         if ((r_state == DRAIN) && out_ready) r_row <= w_rowDone ? '0 : r_row + 1'b1;
      end
   end

   // Flush cycles push zeros so trailing products do not disturb the accumulators.
   for (genvar gi = 0; gi < ROWS; gi++) begin : gAIn
      assign w_aIn[gi] = (r_state == FLUSH) ? '0 : a_data[gi*DATA_W +: DATA_W];
   end
   for (genvar gj = 0; gj < COLS; gj++) begin : gBIn
      assign w_bIn[gj] = (r_state == FLUSH) ? '0 : b_data[gj*DATA_W +: DATA_W];
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : gASkew
      if (gi == 0) begin : gPass
         assign w_aSk[gi] = w_aIn[gi];
      end else begin : gDelay
         logic [DATA_W-1:0] r_dly [gi];
         always_ff @(posedge clk) begin
            if (rst || w_clr) begin
               r_dly <= '{default: '0};
            end else if (w_step) begin
               r_dly[0] <= w_aIn[gi];
               for (int k = 1; k < gi; k++) r_dly[k] <= r_dly[k-1];
            end
         end
         assign w_aSk[gi] = r_dly[gi-1];
      end
   end

   for (genvar gj = 0; gj < COLS; gj++) begin : gBSkew
      if (gj == 0) begin : gPass
         assign w_bSk[gj] = w_bIn[gj];
      end else begin : gDelay
         logic [DATA_W-1:0] r_dly [gj];
         always_ff @(posedge clk) begin
            if (rst || w_clr) begin
               r_dly <= '{default: '0};
            end else if (w_step) begin
               r_dly[0] <= w_bIn[gj];
               for (int k = 1; k < gj; k++) r_dly[k] <= r_dly[k-1];
            end
         end
         assign w_bSk[gj] = r_dly[gj-1];
      end
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : gRowEdge
      assign w_aH[gi][0] = w_aSk[gi];
   end
   for (genvar gj = 0; gj < COLS; gj++) begin : gColEdge
      assign w_bV[0][gj] = w_bSk[gj];
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : gRow
      for (genvar gj = 0; gj < COLS; gj++) begin : gCol
         systolic_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk   (clk),
            .rst   (rst),
            .i_clr (w_clr),
            .i_en  (w_step),
            .i_a   (w_aH[gi][gj]),
            .i_b   (w_bV[gi][gj]),
            .o_a   (w_aH[gi][gj+1]),
            .o_b   (w_bV[gi+1][gj]),
            .o_acc (w_acc[gi][gj])
         );
      end
   end

   always_comb begin
      w_rowData = '0;
      for (int j = 0; j < COLS; j++) w_rowData[j*ACC_W +: ACC_W] = w_acc[r_row][j];
   end

   // Outputs are forced quiet while reset is held, independent of the stale state.
   assign in_ready  = !rst && (r_state == LOAD);
   assign out_valid = !rst && (r_state == DRAIN);
   assign out_last  = out_valid && (r_row == ROW_W'(ROWS - 1));
   assign out_row   = out_valid ? r_row : '0;
   assign out_data  = out_valid ? w_rowData : '0;
   assign busy      = !rst && (r_state != IDLE);
   assign done      = !rst && w_rowDone;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomised scoreboard bench for systolic_mac_array, with a second 32-bit-accumulator
// instance for the wrap-around case.
module tb_systolic_mac_array;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DW   = 16;
   localparam int AW   = 40;
   localparam int KW   = 16;
   localparam int AW32 = 32;
   localparam int MAXK = 64;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [KW-1:0]       k_len;
   logic                in_valid;
   logic                in_ready;
   logic [ROWS*DW-1:0]  a_data;
   logic [COLS*DW-1:0]  b_data;
   logic                out_valid;
   logic                out_ready;
   logic [COLS*AW-1:0]  out_data;
   logic [1:0]          out_row;
   logic                out_last;
   logic                busy;
   logic                done;

   logic                start32;
   logic [KW-1:0]       k_len32;
   logic                in_valid32;
   logic                in_ready32;
   logic [ROWS*DW-1:0]  a_data32;
   logic [COLS*DW-1:0]  b_data32;
   logic                out_valid32;
   logic                out_ready32;
   logic [COLS*AW32-1:0] out_data32;
   logic [1:0]          out_row32;
   logic                out_last32;
   logic                busy32;
   logic                done32;

   typedef struct {
      logic [1:0]         row;
      logic [COLS*AW-1:0] data;
      logic               last;
   } exp_t;

   exp_t   expQ[$];
   int     mA [ROWS][MAXK];
   int     mB [MAXK][COLS];
   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   int     doneCount = 0;
   int     firstValidCyc = -1;
   int     startCyc = 0;
   bit     inReadySeen = 0;
   bit     stallOutMode = 0;
   int     rows32 = 0;
   logic [AW32-1:0] exp32 = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_mac_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .KLEN_W(KW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
      .in_ready(in_ready), .a_data(a_data), .b_data(b_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_last(out_last),
      .busy(busy), .done(done));

   systolic_mac_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW32), .KLEN_W(KW)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .k_len(k_len32), .in_valid(in_valid32),
      .in_ready(in_ready32), .a_data(a_data32), .b_data(b_data32), .out_valid(out_valid32),
      .out_ready(out_ready32), .out_data(out_data32), .out_row(out_row32), .out_last(out_last32),
      .busy(busy32), .done(done32));

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_in_ready"},  in_ready,  0);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_out_last"},  out_last,  0);
      checkOutput({tag, "_out_row"},   out_row,   0);
      checkOutput({tag, "_out_data"},  out_data,  0);
      checkOutput({tag, "_busy"},      busy,      0);
      checkOutput({tag, "_done"},      done,      0);
   endtask

   // Reference: C = A x B with plain integer arithmetic, truncated to the accumulator width.
   function automatic logic [COLS*AW-1:0] refRow(input int i, input int k);
      logic [COLS*AW-1:0] r;
      longint             sum;
      logic [63:0]        s64;
      r = '0;
      for (int j = 0; j < COLS; j++) begin
         sum = 0;
         for (int kk = 0; kk < k; kk++) sum += longint'(mA[i][kk]) * longint'(mB[kk][j]);
         s64 = sum;
         r[j*AW +: AW] = s64[AW-1:0];
      end
      return r;
   endfunction

   task automatic fillRandom(input int k);
      for (int kk = 0; kk < k; kk++) begin
         for (int i = 0; i < ROWS; i++) mA[i][kk] = int'(shortint'($urandom));
         for (int j = 0; j < COLS; j++) mB[kk][j] = int'(shortint'($urandom));
      end
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         if (firstValidCyc < 0) firstValidCyc = cyc;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_row", out_valid, 0);
         end else begin
            checkOutput("row_index", out_row, expQ[0].row);
            checkOutput("row_data",  out_data, expQ[0].data);
            checkOutput("row_last",  out_last, expQ[0].last);
            checkOutput("done_at_last_handshake", done, out_ready && expQ[0].last);
            if (out_ready) void'(expQ.pop_front());
         end
      end else if (done) begin
         checkOutput("done_without_valid", done, 0);
      end
      if (done) doneCount++;
      if (in_ready) inReadySeen = 1;
   end

   always @(negedge clk) begin
      if (out_valid32 && out_ready32) begin
         checkOutput("acc32_row_data", out_data32, {COLS{exp32}});
         checkOutput("acc32_row_index", out_row32, rows32[1:0]);
         rows32++;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = !stallOutMode || (cyc % 4 == 3);
      end
   end

   // abortAt >= 0 resets the DUT that many cycles into FLUSH instead of finishing the job.
   task automatic applyStimulus(input int k, input bit stallIn, input bit stallOut, input int abortAt);
      exp_t e;
      int   beat;
      int   guard;
      bit   accepted;
      for (int r = 0; r < ROWS; r++) begin
         e.row  = 2'(r);
         e.data = refRow(r, k);
         e.last = (r == ROWS - 1);
         expQ.push_back(e);
      end
      stallOutMode  = stallOut;
      doneCount     = 0;
      inReadySeen   = 0;
      firstValidCyc = -1;
      @(posedge clk); #1;
      start    = 1'b1;
      k_len    = KW'(k);
      startCyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      beat  = 0;
      guard = 0;
      while (beat < k && guard < 2000) begin
         in_valid = stallIn ? (guard % 2 == 1) : 1'b1;
         for (int i = 0; i < ROWS; i++)
            a_data[i*DW +: DW] = in_valid ? DW'(mA[i][beat]) : DW'($urandom);
         for (int j = 0; j < COLS; j++)
            b_data[j*DW +: DW] = in_valid ? DW'(mB[beat][j]) : DW'($urandom);
         @(negedge clk);
         accepted = in_valid && in_ready;
         @(posedge clk); #1;
         if (accepted) beat++;
         guard++;
      end
      in_valid = 1'b0;
      if (abortAt >= 0) begin
         repeat (abortAt) @(posedge clk);
         #1;
         rst = 1'b1;
         expQ.delete();
         @(negedge clk);
         checkReset("mid_flush_reset");
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         checkReset("after_abort");
         stallOutMode = 0;
         return;
      end
      guard = 0;
      while (doneCount == 0 && guard < 500) begin
         @(posedge clk);
         guard++;
      end
      repeat (3) @(posedge clk);
      checkOutput("done_once", doneCount, 1);
      checkOutput("all_rows_seen", expQ.size(), 0);
      if (!stallIn && !stallOut)
         checkOutput("row0_latency_bound", (firstValidCyc >= 0) && (firstValidCyc - startCyc <= k + ROWS + COLS), 1);
      if (k == 0) checkOutput("in_ready_never_rises", inReadySeen, 0);
      expQ.delete();
      stallOutMode = 0;
   endtask

   task automatic runWrap32();
      logic [63:0] p;
      int          beat;
      int          guard;
      p      = 64'(longint'(32767) * longint'(32767) * 3);
      exp32  = p[AW32-1:0];
      rows32 = 0;
      for (int i = 0; i < ROWS; i++) a_data32[i*DW +: DW] = 16'h7FFF;
      for (int j = 0; j < COLS; j++) b_data32[j*DW +: DW] = 16'h7FFF;
      @(posedge clk); #1;
      start32 = 1'b1;
      k_len32 = KW'(3);
      @(posedge clk); #1;
      start32    = 1'b0;
      in_valid32 = 1'b1;
      beat  = 0;
      guard = 0;
      while (beat < 3 && guard < 100) begin
         @(negedge clk);
         if (in_ready32) beat++;
         @(posedge clk); #1;
         guard++;
      end
      in_valid32 = 1'b0;
      guard = 0;
      while (rows32 < ROWS && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      checkOutput("acc32_rows_drained", rows32, ROWS);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      k_len      = '0;
      in_valid   = 1'b0;
      a_data     = '0;
      b_data     = '0;
      start32    = 1'b0;
      k_len32    = '0;
      in_valid32 = 1'b0;
      a_data32   = '0;
      b_data32   = '0;
      out_ready32 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkReset("during_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkReset("first_cycle_after_reset");

      $display("[TB] identity A, B[k][j]=4k+j, k_len=4");
      for (int kk = 0; kk < 4; kk++) begin
         for (int i = 0; i < ROWS; i++) mA[i][kk] = (i == kk) ? 1 : 0;
         for (int j = 0; j < COLS; j++) mB[kk][j] = kk * 4 + j;
      end
      applyStimulus(4, 0, 0, -1);

      $display("[TB] constant -3 x 5, k_len=10");
      for (int kk = 0; kk < 10; kk++) begin
         for (int i = 0; i < ROWS; i++) mA[i][kk] = -3;
         for (int j = 0; j < COLS; j++) mB[kk][j] = 5;
      end
      applyStimulus(10, 0, 0, -1);

      $display("[TB] random k_len=6 without and with stalls");
      fillRandom(6);
      applyStimulus(6, 0, 0, -1);
      applyStimulus(6, 1, 1, -1);

      $display("[TB] k_len=0");
      applyStimulus(0, 0, 0, -1);

      $display("[TB] 32-bit accumulator wrap");
      runWrap32();

      $display("[TB] reset during FLUSH then fresh job");
      fillRandom(5);
      applyStimulus(5, 0, 0, 2);
      fillRandom(7);
      applyStimulus(7, 0, 0, -1);

      $display("[TB] random jobs");
      for (int t = 0; t < 4; t++) begin
         int kr;
         kr = int'($urandom_range(1, 12));
         fillRandom(kr);
         applyStimulus(kr, 1'($urandom), 1'($urandom), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
